// File: rtl/fir_tap_sequencer_if.sv
// rtl/fir_tap_sequencer_if.sv - operand/handshake bundle between filter control and the float16 PE
// Purpose: groups coefficient write, sample input, PE operand and filter output signals.
// Ports (modport slave = sequencer side):
//   coef_we/coef_addr/coef_data  coefficient register write
//   in_valid/in_data/in_ready    sample input handshake
//   pe_clear/pe_a/pe_b/pe_result PE accumulator clear, operands, accumulated result
//   out_valid/out_data/out_ready filter output handshake
interface fir_tap_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 3
);
    logic                  coef_we;
    logic [IDX_WIDTH-1:0]  coef_addr;
    logic [DATA_WIDTH-1:0] coef_data;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  pe_clear;
    logic [DATA_WIDTH-1:0] pe_a;
    logic [DATA_WIDTH-1:0] pe_b;
    logic [DATA_WIDTH-1:0] pe_result;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    modport slave (
        input  coef_we, coef_addr, coef_data, in_valid, in_data, pe_result, out_ready,
        output in_ready, pe_clear, pe_a, pe_b, out_valid, out_data
    );

    modport master (
        output coef_we, coef_addr, coef_data, in_valid, in_data, pe_result, out_ready,
        input  in_ready, pe_clear, pe_a, pe_b, out_valid, out_data
    );
endinterface

// File: rtl/fir_tap_sequencer.sv
// rtl/fir_tap_sequencer.sv - tap sequencer feeding (sample, coefficient) pairs to a float16 MAC PE
// Purpose: holds the TAPS-deep sample delay line and coefficient file; per accepted sample it
//   clears the PE, streams TAPS operand pairs, captures the PE sum and offers it downstream.
// Ports: clk, reset (async, active-high), bus (fir_tap_sequencer_if.slave);
//   sample_cnt (16-bit output handshake counter) only when SEQ_SAMPLE_CNT_EN is defined.
module fir_tap_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int TAPS       = 8,
    parameter int IDX_WIDTH  = 3
) (
    input  logic                   clk,
    input  logic                   reset,
`ifdef SEQ_SAMPLE_CNT_EN
    output logic [15:0]            sample_cnt,
`endif
    fir_tap_sequencer_if.slave     bus
);
    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN, S_OUT} state_t;

    // One extra bit so the counter can reach TAPS even when TAPS == 2**IDX_WIDTH.
    localparam logic [IDX_WIDTH:0] TAPS_CNT = (IDX_WIDTH+1)'(TAPS);

    state_t                state_q, state_d;
    logic [IDX_WIDTH:0]    idx_q, idx_d;
    logic                  pe_clear_q, pe_clear_d;
    logic [DATA_WIDTH-1:0] pe_a_q, pe_a_d;
    logic [DATA_WIDTH-1:0] pe_b_q, pe_b_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [DATA_WIDTH-1:0] x_q [TAPS];
    logic [DATA_WIDTH-1:0] x_d [TAPS];
    logic [DATA_WIDTH-1:0] c_q [TAPS];
    logic [DATA_WIDTH-1:0] c_d [TAPS];
`ifdef SEQ_SAMPLE_CNT_EN
    logic [15:0]           cnt_q, cnt_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            pe_clear_q  <= 1'b1;
            pe_a_q      <= '0;
            pe_b_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
                c_q[i] <= '0;
            end
`ifdef SEQ_SAMPLE_CNT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pe_clear_q  <= pe_clear_d;
            pe_a_q      <= pe_a_d;
            pe_b_q      <= pe_b_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= x_d[i];
                c_q[i] <= c_d[i];
            end
`ifdef SEQ_SAMPLE_CNT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pe_clear_d  = pe_clear_q;
        pe_a_d      = pe_a_q;
        pe_b_d      = pe_b_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        x_d         = x_q;
        c_d         = c_q;
`ifdef SEQ_SAMPLE_CNT_EN
        cnt_d       = cnt_q;
`endif

        // Coefficients only change between samples; c_q[0] below is the pre-edge value.
        if (state_q == S_IDLE && bus.coef_we && ({1'b0, bus.coef_addr} < TAPS_CNT)) begin
            c_d[bus.coef_addr] = bus.coef_data;
        end

        case (state_q)
            S_IDLE: begin
                pe_clear_d = 1'b1;
                pe_a_d     = '0;
                pe_b_d     = '0;
                if (bus.in_valid) begin
                    x_d[0] = bus.in_data;
                    for (int i = 1; i < TAPS; i++) begin
                        x_d[i] = x_q[i-1];
                    end
                    pe_clear_d = 1'b0;
                    pe_a_d     = bus.in_data;
                    pe_b_d     = c_q[0];
                    idx_d      = 1;
                    state_d    = S_MAC;
                end
            end
            S_MAC: begin
                if (idx_q == TAPS_CNT) begin
                    pe_a_d  = '0;
                    pe_b_d  = '0;
                    state_d = S_DRAIN;
                end else begin
                    pe_a_d = x_q[idx_q[IDX_WIDTH-1:0]];
                    pe_b_d = c_q[idx_q[IDX_WIDTH-1:0]];
                    idx_d  = idx_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // PE output is registered, so the pre-edge value already holds all TAPS products.
                out_data_d  = bus.pe_result;
                out_valid_d = 1'b1;
                pe_clear_d  = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
`ifdef SEQ_SAMPLE_CNT_EN
                    cnt_d       = cnt_q + 16'd1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.pe_clear  = pe_clear_q;
    assign bus.pe_a      = pe_a_q;
    assign bus.pe_b      = pe_b_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
`ifdef SEQ_SAMPLE_CNT_EN
    assign sample_cnt    = cnt_q;
`endif
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb/tb_fir_tap_sequencer.sv - directed-vector bench for fir_tap_sequencer with a float16 MAC PE model
module tb_fir_tap_sequencer;
    logic clk = 1'b0;
    logic reset;
`ifdef SEQ_SAMPLE_CNT_EN
    logic [15:0] sample_cnt;
`endif

    fir_tap_sequencer_if #(.DATA_WIDTH(16), .IDX_WIDTH(3)) bus ();

    fir_tap_sequencer #(.DATA_WIDTH(16), .TAPS(8), .IDX_WIDTH(3)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef SEQ_SAMPLE_CNT_EN
        .sample_cnt (sample_cnt),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic real h2r(input logic [15:0] h);
        real m;
        int  e;
        e = int'(h[14:10]);
        if (e == 0) m = real'(h[9:0]) * (2.0 ** -24);
        else        m = (1.0 + real'(h[9:0]) / 1024.0) * (2.0 ** (e - 15));
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2h(input real r);
        logic        s;
        int          e;
        int          mant;
        logic [15:0] h;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        if (s) r = -r;
        e = 15;
        while (r >= 2.0) begin r = r / 2.0; e++; end
        while (r < 1.0)  begin r = r * 2.0; e--; end
        mant = int'((r - 1.0) * 1024.0);
        h = {s, e[4:0], mant[9:0]};
        return h;
    endfunction

    // PE model: registered accumulator, synchronously cleared by pe_clear.
    real acc;
    always @(posedge clk or posedge reset) begin
        if (reset)             acc <= 0.0;
        else if (bus.pe_clear) acc <= 0.0;
        else                   acc <= acc + h2r(bus.pe_a) * h2r(bus.pe_b);
    end
    assign bus.pe_result = r2h(acc);

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr_coef(input logic [2:0] a, input logic [15:0] d);
        bus.coef_we = 1'b1; bus.coef_addr = a; bus.coef_data = d;
        @(negedge clk);
        bus.coef_we = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input bit poke,
                        output logic [15:0] res, output int lat, output int clr_low);
        int w;
        w = 0;
        while (!bus.in_ready && w < 50) begin @(negedge clk); w++; end
        chk("in_ready_before_send", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1; bus.in_data = d;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0; clr_low = 0;
        while (!bus.out_valid && lat < 40) begin
            if (!bus.pe_clear) clr_low++;
            if (poke && lat == 2) begin
                bus.coef_we = 1'b1; bus.coef_addr = 3'd0; bus.coef_data = 16'h4400;
            end else begin
                bus.coef_we = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.coef_we = 1'b0;
        res = bus.out_data;
        if (bus.out_ready) @(negedge clk);
    endtask

    logic [15:0] res, held;
    int lat, clr;
    logic [15:0] exp_t3 [8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h3800, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] coef_t3 [8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h3800, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] exp_t4 [8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800};
`ifdef SEQ_SAMPLE_CNT_EN
    logic [15:0] cnt_before;
`endif

    initial begin
        bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_pe_clear", 32'(bus.pe_clear), 32'd1);
        chk("rst_pe_a", 32'(bus.pe_a), 32'd0);
        chk("rst_pe_b", 32'(bus.pe_b), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
`ifdef SEQ_SAMPLE_CNT_EN
        chk("rst_sample_cnt", 32'(sample_cnt), 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // Single tap of 1.0: latency and pe_clear window.
        wr_coef(3'd0, 16'h3C00);
        send(16'h4000, 1'b0, res, lat, clr);
        chk("t1_latency", 32'(lat), 32'd9);
        chk("t1_out_data", 32'(res), 32'h4000);
        chk("t1_pe_clear_low", 32'(clr), 32'd9);

        // Impulse walks through the coefficient file.
        do_reset();
        for (int k = 0; k < 8; k++) wr_coef(3'(k), coef_t3[k]);
        for (int k = 0; k < 8; k++) begin
            send((k == 0) ? 16'h3C00 : 16'h0000, 1'b0, res, lat, clr);
            chk($sformatf("t3_out%0d", k), 32'(res), 32'(exp_t3[k]));
        end

        // All taps 0.5, constant 2.0 input: running sum 1.0 .. 8.0.
        for (int k = 0; k < 8; k++) wr_coef(3'(k), 16'h3800);
        for (int k = 0; k < 8; k++) begin
            send(16'h4000, 1'b0, res, lat, clr);
            chk($sformatf("t4_out%0d", k), 32'(res), 32'(exp_t4[k]));
        end

        // Output backpressure; full line of 2.0 * 0.5 -> 8.0.
        bus.out_ready = 1'b0;
`ifdef SEQ_SAMPLE_CNT_EN
        cnt_before = sample_cnt;
`endif
        send(16'h4000, 1'b0, res, lat, clr);
        chk("t5_first_data", 32'(res), 32'h4800);
        bus.in_valid = 1'b1; bus.in_data = 16'h5555;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("t5_hold_valid%0d", k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("t5_hold_data%0d", k), 32'(bus.out_data), 32'h4800);
            chk($sformatf("t5_hold_in_ready%0d", k), 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t5_release_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_release_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef SEQ_SAMPLE_CNT_EN
        chk("t5_sample_cnt", 32'(sample_cnt), 32'(cnt_before + 16'd1));
`endif

        // Coefficient write during MAC is dropped; in IDLE it sticks.
        do_reset();
        wr_coef(3'd0, 16'h3C00);
        send(16'h4000, 1'b1, res, lat, clr);
        chk("t6_during_mac", 32'(res), 32'h4000);
        send(16'h3C00, 1'b0, res, lat, clr);
        chk("t6_old_c0_kept", 32'(res), 32'h3C00);
        wr_coef(3'd0, 16'h4400);
        send(16'h3C00, 1'b0, res, lat, clr);
        chk("t6_idle_write", 32'(res), 32'h4400);

        // Reset while idx == 4 aborts the sample.
        for (int k = 0; k < 8; k++) wr_coef(3'(k), 16'h3C00);
        bus.in_valid = 1'b1; bus.in_data = 16'h4000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t7_mid_mac_pe_clear", 32'(bus.pe_clear), 32'd0);
        reset = 1'b1;
        #1;
        chk("t7_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t7_rst_pe_clear", 32'(bus.pe_clear), 32'd1);
        chk("t7_rst_pe_a", 32'(bus.pe_a), 32'd0);
        chk("t7_rst_pe_b", 32'(bus.pe_b), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t7_in_ready", 32'(bus.in_ready), 32'd1);
        send(16'h3C00, 1'b0, res, lat, clr);
        chk("t7_zero_coef", 32'(res), 32'h0000);
        chk("t7_latency", 32'(lat), 32'd9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
